ntt_bu_sched: RTL and testbench
===============================

# ntt_bu_sched

Sequencing controller for one pipelined radix-2 butterfly (B0 = A0 + Y·A1 mod q, B1 = A0 − Y·A1 mod q) performing a full in-place N-point Cooley–Tukey NTT over a dual-port coefficient RAM. For every stage it generates the coefficient read pair, twiddle ROM address, and delayed write-back pair, then drains the pipeline before the next stage. It sits between the top-level NTT command interface and the butterfly/RAM/twiddle-ROM datapath and has no data path of its own.

## Interface
- N_LOG2, 4, log2 of transform size N (N = 16); legal range 2..12
- BU_LAT, 4, butterfly latency in cycles from A0/A1/Y valid to B0/B1 valid; legal range 1..16
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a full transform; sampled only in IDLE
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse at transform completion
- stage  out  N_LOG2  current stage index s
- rd_en  out  1  coefficient RAM read strobe (RAM read latency is 1 cycle)
- rd_addr0 / rd_addr1  out  N_LOG2 each  butterfly operand addresses
- tw_addr  out  N_LOG2-1  twiddle ROM address (ROM holds ω^i, i = 0..N/2-1, 1-cycle latency)
- bu_vld  out  1  rd_en delayed 1 cycle; A0/A1/Y valid at butterfly input
- wr_en  out  1  rd_en delayed 1+BU_LAT cycles; B0/B1 valid
- wr_addr0 / wr_addr1  out  N_LOG2 each  rd_addr0/rd_addr1 delayed 1+BU_LAT cycles

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 → ISSUE, s=0, j=0. start ignored in all other states.
- ISSUE: rd_en=1 every cycle, j = 0..N/2−1; after j = N/2−1 → DRAIN.
- Addressing for stage s, m = 2^s: g = j >> s, k = j & (m−1); rd_addr0 = g·2m + k; rd_addr1 = rd_addr0 + m; tw_addr = k << (N_LOG2−1−s). All arithmetic unsigned, no wrap (rd_addr1 ≤ N−1 by construction).
- DRAIN: rd_en=0 for exactly 1+BU_LAT cycles; write pipeline continues. Exit: s < N_LOG2−1 → ISSUE with s+1, j=0; else → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Write pipeline: (1+BU_LAT)-deep shift register of {rd_en, rd_addr0, rd_addr1}; bu_vld tap at depth 1, wr_en/wr_addr taps at depth 1+BU_LAT. Runs independently of FSM state.
- Input ordering: RAM preloaded bit-reversed; output natural order. Controller does no reordering.

## Timing
- Reset values: state IDLE; busy, done, rd_en, bu_vld, wr_en = 0; stage, rd_addr*, tw_addr, wr_addr* = 0; entire write pipeline cleared.
- rst mid-operation: next cycle all outputs at reset values; no wr_en asserted afterward for in-flight reads.
- Cycle 0: start sampled in IDLE. Cycle 1: first rd_en.
- Per stage: N/2 ISSUE + (1+BU_LAT) DRAIN cycles.
- done asserted in cycle 1 + N_LOG2·(N/2 + 1 + BU_LAT); defaults: cycle 53.
- Last write of stage s occurs in last DRAIN cycle; first read of stage s+1 follows next cycle (RAM write-before-read across cycles, no same-cycle bypass needed).
- Exactly N_LOG2·N/2 rd_en and the same number of wr_en pulses per transform.
- start held high continuously: new transform begins one cycle after done (IDLE re-entry).

## Test plan
- Reset: assert rst 3 cycles mid-random state → all outputs 0 on cycle after first rst; busy=0.
- Stage 0/1 addressing (defaults): stage 0, j=1 → rd (2,3), tw 0; stage 1, j=1 → rd (1,3), tw 4; stage 1, j=2 → rd (4,6), tw 0.
- Stage 3 addressing: j=5 → rd (5,13), tw 5; j=7 → rd (7,15), tw 7.
- Write alignment: first wr_en at cycle 6 with wr (0,1); every wr_en/wr_addr equals rd_en/rd_addr 5 cycles earlier; bu_vld equals rd_en 1 cycle earlier.
- Completion/protocol: done single pulse at cycle 53; 32 rd_en, 32 wr_en; start pulses during ISSUE/DRAIN/DONE ignored (no restart, counts unchanged).
- Reset mid-stage 2 ISSUE: no wr_en after reset; subsequent start runs full transform, done 53 cycles later; N_LOG2=3, BU_LAT=1 run: done at cycle 19.

Source files
------------

// File: rtl/ntt_bu_sched.sv
// Stage/address sequencer for one pipelined radix-2 butterfly running an in-place
// N-point Cooley-Tukey NTT; issues read pairs, twiddle addresses and delayed write-backs.
module ntt_bu_sched #(
    parameter int N_LOG2 = 4,
    parameter int BU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_LOG2-1:0] stage,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr0,
    output logic [N_LOG2-1:0] rd_addr1,
    output logic [N_LOG2-2:0] tw_addr,
    output logic              bu_vld,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr0,
    output logic [N_LOG2-1:0] wr_addr1
);
    localparam int JW = N_LOG2 - 1;
    localparam int DW = $clog2(BU_LAT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [JW-1:0]                 j_q, j_d;
    logic [N_LOG2-1:0]             s_q, s_d;
    logic [DW-1:0]                 dcnt_q, dcnt_d;
    logic [BU_LAT:0]               vld_pipe_q, vld_pipe_d;
    logic [BU_LAT:0][N_LOG2-1:0]   a0_pipe_q, a0_pipe_d, a1_pipe_q, a1_pipe_d;

    logic [N_LOG2-1:0] j_ext, m, k, g, base;

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        s_d     = s_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                j_d     = '0;
                s_d     = '0;
            end
            ISSUE: begin
                if (j_q == {JW{1'b1}}) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            DRAIN: begin
                // hold off the next stage until every write of this one has landed
                if (dcnt_q == DW'(BU_LAT)) begin
                    if (s_q == N_LOG2'(N_LOG2 - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        s_d     = s_q + N_LOG2'(1);
                        j_d     = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // j splits into group g and offset k within the half-block of size m = 2^s
    always_comb begin
        j_ext = {1'b0, j_q};
        m     = N_LOG2'(1) << s_q;
        k     = j_ext & (m - N_LOG2'(1));
        g     = j_ext >> s_q;
        base  = (g << (s_q + N_LOG2'(1))) + k;
    end

    always_comb begin
        busy     = (state_q == ISSUE) || (state_q == DRAIN);
        done     = (state_q == DONE);
        stage    = s_q;
        rd_en    = (state_q == ISSUE);
        rd_addr0 = rd_en ? base : '0;
        rd_addr1 = rd_en ? base + m : '0;
        tw_addr  = rd_en ? (JW'(k) << (N_LOG2'(JW) - s_q)) : '0;
    end

    always_comb begin
        vld_pipe_d = {vld_pipe_q[BU_LAT-1:0], rd_en};
        a0_pipe_d  = {a0_pipe_q[BU_LAT-1:0], rd_addr0};
        a1_pipe_d  = {a1_pipe_q[BU_LAT-1:0], rd_addr1};
        bu_vld     = vld_pipe_q[0];
        wr_en      = vld_pipe_q[BU_LAT];
        wr_addr0   = a0_pipe_q[BU_LAT];
        wr_addr1   = a1_pipe_q[BU_LAT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            s_q        <= '0;
            dcnt_q     <= '0;
            vld_pipe_q <= '0;
            a0_pipe_q  <= '0;
            a1_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            s_q        <= s_d;
            dcnt_q     <= dcnt_d;
            vld_pipe_q <= vld_pipe_d;
            a0_pipe_q  <= a0_pipe_d;
            a1_pipe_q  <= a1_pipe_d;
        end
    end
endmodule

// File: tb/tb_ntt_bu_sched.sv
// Bench for ntt_bu_sched: per-cycle comparison against a schedule model derived from
// the stage/slot arithmetic, for the default build and a N_LOG2=3, BU_LAT=1 build.
module tb_ntt_bu_sched;
    logic clk = 1'b0;
    logic rst, start, start_s;
    always #5 clk = ~clk;

    logic       busy, done, rd_en, bu_vld, wr_en;
    logic [3:0] stage, a0, a1, w0, w1;
    logic [2:0] tw;
    logic       busy_s, done_s, rd_en_s, bu_vld_s, wr_en_s;
    logic [2:0] stage_s, a0_s, a1_s, w0_s, w1_s;
    logic [1:0] tw_s;

    ntt_bu_sched #(.N_LOG2(4), .BU_LAT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr0(a0), .rd_addr1(a1), .tw_addr(tw), .bu_vld(bu_vld),
        .wr_en(wr_en), .wr_addr0(w0), .wr_addr1(w1));

    ntt_bu_sched #(.N_LOG2(3), .BU_LAT(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .stage(stage_s),
        .rd_en(rd_en_s), .rd_addr0(a0_s), .rd_addr1(a1_s), .tw_addr(tw_s), .bu_vld(bu_vld_s),
        .wr_en(wr_en_s), .wr_addr0(w0_s), .wr_addr1(w1_s));

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] stage;
        logic       rd_en;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [3:0] tw;
        logic       bu_vld;
        logic       wr_en;
        logic [3:0] w0;
        logic [3:0] w1;
    } obs_t;

    obs_t ob, os;
    assign ob = {busy, done, stage, rd_en, a0, a1, {1'b0, tw}, bu_vld, wr_en, w0, w1};
    assign os = {busy_s, done_s, {1'b0, stage_s}, rd_en_s, {1'b0, a0_s}, {1'b0, a1_s},
                 {2'b00, tw_s}, bu_vld_s, wr_en_s, {1'b0, w0_s}, {1'b0, w1_s}};

    int total = 0;
    int bad   = 0;

    // t counts cycles from the one in which start is sampled; returns the read issued at t
    function automatic bit rd_slot(int t, int nl, int bl, output int ra0, output int ra1,
                                   output int rtw);
        int half, p, s, j, m;
        half = 1 << (nl - 1);
        p    = half + 1 + bl;
        ra0 = 0; ra1 = 0; rtw = 0;
        if (t < 1 || t > nl * p) return 1'b0;
        s = (t - 1) / p;
        j = (t - 1) % p;
        if (j >= half) return 1'b0;
        m   = 1 << s;
        ra0 = (j / m) * 2 * m + (j % m);
        ra1 = ra0 + m;
        rtw = (j % m) << (nl - 1 - s);
        return 1'b1;
    endfunction

    function automatic obs_t exp_at(int t, int nl, int bl);
        obs_t e;
        int p, x0, x1, xt;
        e = '0;
        p = (1 << (nl - 1)) + 1 + bl;
        if (t >= 1 && t <= nl * p) begin
            e.busy  = 1'b1;
            e.stage = 4'((t - 1) / p);
        end
        e.done = (t == nl * p + 1);
        if (rd_slot(t, nl, bl, x0, x1, xt)) begin
            e.rd_en = 1'b1; e.a0 = 4'(x0); e.a1 = 4'(x1); e.tw = 4'(xt);
        end
        e.bu_vld = rd_slot(t - 1, nl, bl, x0, x1, xt);
        if (rd_slot(t - 1 - bl, nl, bl, x0, x1, xt)) begin
            e.wr_en = 1'b1; e.w0 = 4'(x0); e.w1 = 4'(x1);
        end
        return e;
    endfunction

    // stage is unspecified outside busy, so only compare it there
    function automatic obs_t msk(obs_t o);
        if (!o.busy) o.stage = '0;
        return o;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_s = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (ob !== '0) begin bad++; $display("FAIL reset_big got=%h exp=%h", ob, obs_t'('0)); end
        total++;
        if (os !== '0) begin bad++; $display("FAIL reset_small got=%h exp=%h", os, obs_t'('0)); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_transform();
        int rds = 0, wrs = 0, dns = 0;
        obs_t e;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        for (int t = 0; t <= 57; t++) begin
            if (t > 0) @(negedge clk);
            e = exp_at(t, 4, 4);
            total++;
            if (msk(ob) !== e) begin
                bad++; $display("FAIL transform t=%0d got=%h exp=%h", t, msk(ob), e);
            end
            rds += int'(rd_en); wrs += int'(wr_en); dns += int'(done);
            // extra start pulses while busy or done must be ignored
            start = (t == 0) ? 1'b1 : (t <= 53 ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        start = 1'b0;
        total++;
        if (rds !== 32) begin bad++; $display("FAIL rd_count got=%0d exp=32", rds); end
        total++;
        if (wrs !== 32) begin bad++; $display("FAIL wr_count got=%0d exp=32", wrs); end
        total++;
        if (dns !== 1) begin bad++; $display("FAIL done_count got=%0d exp=1", dns); end
    endtask

    task automatic test_addressing();
        int tt[5]  = '{2, 15, 16, 45, 47};
        int ta0[5] = '{2, 1, 4, 5, 7};
        int ta1[5] = '{3, 3, 6, 13, 15};
        int ttw[5] = '{0, 4, 0, 5, 7};
        @(negedge clk);
        for (int t = 0; t <= 54; t++) begin
            if (t > 0) @(negedge clk);
            start = (t == 0);
            for (int i = 0; i < 5; i++) begin
                if (t == tt[i]) begin
                    total++;
                    if ({ob.rd_en, ob.a0, ob.a1, ob.tw} !== {1'b1, 4'(ta0[i]), 4'(ta1[i]), 4'(ttw[i])}) begin
                        bad++;
                        $display("FAIL addr t=%0d got=%b/%0d/%0d/%0d exp=1/%0d/%0d/%0d",
                                 t, ob.rd_en, ob.a0, ob.a1, ob.tw, ta0[i], ta1[i], ttw[i]);
                    end
                end
            end
            if (t == 5 || t == 6) begin
                total++;
                if ({ob.wr_en, ob.w0, ob.w1} !== ((t == 6) ? 9'b1_0000_0001 : 9'b0)) begin
                    bad++; $display("FAIL first_wr t=%0d got=%b/%0d/%0d", t, ob.wr_en, ob.w0, ob.w1);
                end
            end
            if (t == 1 || t == 2) begin
                total++;
                if (ob.bu_vld !== (t == 2)) begin
                    bad++; $display("FAIL first_bu_vld t=%0d got=%b", t, ob.bu_vld);
                end
            end
            if (t == 52 || t == 53) begin
                total++;
                if (ob.done !== (t == 53)) begin
                    bad++; $display("FAIL done_cycle t=%0d got=%b exp=%b", t, ob.done, t == 53);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dns = 0;
        obs_t e;
        @(negedge clk);
        for (int t = 0; t <= 110; t++) begin
            if (t > 0) @(negedge clk);
            e = (t < 54) ? exp_at(t, 4, 4) : exp_at(t - 54, 4, 4);
            total++;
            if (msk(ob) !== e) begin
                bad++; $display("FAIL back_to_back t=%0d got=%h exp=%h", t, msk(ob), e);
            end
            dns += int'(done);
            start = (t <= 54);
        end
        start = 1'b0;
        total++;
        if (dns !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dns); end
    endtask

    task automatic test_reset_mid();
        int rt;
        obs_t e;
        rt = $urandom_range(27, 34);
        @(negedge clk);
        for (int t = 0; t <= rt; t++) begin
            if (t > 0) @(negedge clk);
            e = exp_at(t, 4, 4);
            total++;
            if (msk(ob) !== e) begin
                bad++; $display("FAIL pre_rst t=%0d got=%h exp=%h", t, msk(ob), e);
            end
            start = (t == 0);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (ob !== '0) begin bad++; $display("FAIL reset_mid got=%h exp=%h", ob, obs_t'('0)); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if (ob !== '0) begin bad++; $display("FAIL post_rst c=%0d got=%h exp=0", c, ob); end
        end
        for (int t = 0; t <= 56; t++) begin
            if (t > 0) @(negedge clk);
            e = exp_at(t, 4, 4);
            total++;
            if (msk(ob) !== e) begin
                bad++; $display("FAIL rerun t=%0d got=%h exp=%h", t, msk(ob), e);
            end
            start = (t == 0);
        end
        start = 1'b0;
    endtask

    task automatic test_small();
        obs_t e;
        @(negedge clk);
        for (int t = 0; t <= 22; t++) begin
            if (t > 0) @(negedge clk);
            e = exp_at(t, 3, 1);
            total++;
            if (msk(os) !== e) begin
                bad++; $display("FAIL small t=%0d got=%h exp=%h", t, msk(os), e);
            end
            if (t == 19) begin
                total++;
                if (os.done !== 1'b1) begin bad++; $display("FAIL small_done got=%b exp=1", os.done); end
            end
            start_s = (t == 0);
        end
        start_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_transform();
        test_addressing();
        test_back_to_back();
        test_reset_mid();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
